data_reg_bank_reader: RTL
=========================

// Module: data_reg_bank_reader
// PURPOSE
//  Read-side streamer for the 10-entry data register bank. On a start request it snapshots
//  all bank outputs in one cycle, then emits a programmable run of words (address + data)
//  over a valid/ready stream. Downstream neuron/accumulator logic consumes the words in order.
//  The snapshot isolates the stream from bank writes (writeAddress/writeAll) made mid-run.
// PARAMETERS
//  WIDTH  32  data word width
//  DEPTH  10  number of bank entries; address width AW = 4
// PORTS
//  clk       in   1         system clock, rising edge
//  rst_n     in   1         asynchronous active-low reset
//  regsIn    in   WIDTH*DEPTH  bank outputs; entry k at [k*WIDTH +: WIDTH]
//  start     in   1         request a run (sampled only in IDLE)
//  startAddr in   AW        first entry of the run
//  count     in   AW        number of words to emit, 1..DEPTH
//  dataOut   out  WIDTH     current word (snapshot[addrOut])
//  addrOut   out  AW        bank address of dataOut
//  outValid  out  1         dataOut/addrOut valid
//  outReady  in   1         consumer accepts the word this cycle
//  busy      out  1         high in STREAM
//  done      out  1         one-cycle pulse after the last word is accepted
//  error     out  1         one-cycle pulse when a start is rejected
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; dataOut=0, addrOut=0, outValid=0, busy=0, done=0,
//   error=0; snapshot cleared to 0. Reset mid-run abandons the run; no done pulse follows.
//  States: IDLE -> STREAM -> IDLE. Registered outputs only; no combinational in->out path.
//  IDLE: on start=1 with 1<=count<=DEPTH and startAddr<DEPTH: at that edge copy regsIn
//   into snapshot, load addrOut=startAddr, remaining=count, go STREAM. outValid rises
//   the cycle after start (latency 1); dataOut = regsIn[startAddr] as sampled at start edge.
//  Rejected start (count=0, count>DEPTH, or startAddr>=DEPTH): stay IDLE, error=1 for one cycle.
//  STREAM: handshake = outValid & outReady. Without handshake, dataOut/addrOut/outValid hold.
//   On handshake with remaining>1: addrOut advances, remaining-1, next word valid the
//   next cycle (full throughput: 1 word/cycle while outReady=1).
//   On handshake with remaining=1: outValid=0, busy=0, done=1 next cycle, return IDLE.
//  Address wrap: addrOut increments mod DEPTH (DEPTH-1 -> 0), never 10..15.
//  start asserted while busy is ignored (no error, no restart).
//  regsIn changes after the start edge have no effect on the active run.
//  A new start is accepted on the cycle done is high (state is IDLE).
//  busy = (state==STREAM); outValid is never high in IDLE.
// STRUCTURE
//  Package data_reg_bank_pkg: BANK_DEPTH=10, BANK_WIDTH=32, BANK_AW=4, state encoding
//   ST_IDLE/ST_STREAM; shared with the write-side bank and its bench.
//  Sub-module mod_counter (width AW, modulus DEPTH, load/enable) for addrOut wrap.
//  Snapshot is a DEPTH x WIDTH register array with single-cycle parallel load; output mux
//   indexed by addrOut feeds dataOut register.
// TESTING
//  1 Bank holds 10..19; start, startAddr=0, count=10, outReady=1 -> addrOut 0..9,
//    dataOut 10..19 on 10 consecutive cycles, done pulse once, busy low after.
//  2 startAddr=8, count=4 -> addresses 8,9,0,1 with data 18,19,10,11 (wrap mod 10).
//  3 Backpressure: count=3, outReady toggles 1,0,0,1,0,1 -> each word held stable while
//    stalled; exactly 3 handshakes, no duplication or skip.
//  4 Snapshot isolation: start with bank=0..9, then writeAll 100..109 during run -> stream
//    still returns 0..9.
//  5 Rejects: count=0, count=11, startAddr=10 -> error 1-cycle pulse each, outValid stays 0;
//    start during STREAM ignored.
//  6 rst_n low mid-run (after 2 words) -> all outputs 0 immediately, no done; fresh start
//    after release runs normally.

Source files
------------

// File: rtl/data_reg_bank_pkg.sv
// rtl/data_reg_bank_pkg.sv - shared constants and state encoding for the data register bank
package data_reg_bank_pkg;

   localparam int BANK_DEPTH = 10;
   localparam int BANK_WIDTH = 32;
   localparam int BANK_AW    = 4;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_t;

endpackage

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - loadable modulo counter, exposes the wrapped next value
module mod_counter #(
   parameter int W   = 4,
   parameter int MOD = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic [W-1:0] q,
   output logic [W-1:0] nxt
);

   // Wrap at MOD-1 so the value never enters the unused codes above the modulus
   assign nxt = (q == W'(MOD - 1)) ? '0 : q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (load) begin
         q <= load_val;
      end else if (en) begin
         q <= nxt;
      end
   end

endmodule

// File: rtl/data_reg_bank_reader.sv
// rtl/data_reg_bank_reader.sv - snapshots the data bank and streams a run of address/data words
module data_reg_bank_reader
   import data_reg_bank_pkg::*;
#(
   parameter int WIDTH = BANK_WIDTH,
   parameter int DEPTH = BANK_DEPTH,
   parameter int AW    = BANK_AW
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [WIDTH*DEPTH-1:0] regsIn,
   input  logic               start,
   input  logic [AW-1:0]      startAddr,
   input  logic [AW-1:0]      count,
   output logic [WIDTH-1:0]   dataOut,
   output logic [AW-1:0]      addrOut,
   output logic               outValid,
   input  logic               outReady,
   output logic               busy,
   output logic               done,
   output logic               error
);

   state_t           state;
   logic [WIDTH-1:0] bank_in [DEPTH];
   logic [WIDTH-1:0] snap    [DEPTH];
   logic [AW-1:0]    remaining;
   logic [AW-1:0]    addr_nxt;
   logic             start_ok;
   logic             accept;
   logic             hs;
   logic             advance;

   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         bank_in[k] = regsIn[k*WIDTH +: WIDTH];
      end
   end

   assign start_ok = (count != '0) && (count <= AW'(DEPTH)) && (startAddr < AW'(DEPTH));
   assign accept   = (state == ST_IDLE) && start && start_ok;
   assign hs       = outValid && outReady;
   assign advance  = (state == ST_STREAM) && hs && (remaining > AW'(1));

   mod_counter #(
      .W   (AW),
      .MOD (DEPTH)
   ) u_addr_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept),
      .load_val (startAddr),
      .en       (advance),
      .q        (addrOut),
      .nxt      (addr_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         dataOut   <= '0;
         outValid  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         remaining <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            snap[k] <= '0;
         end
      end else begin
         done  <= 1'b0;
         error <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (start_ok) begin
                     for (int k = 0; k < DEPTH; k++) begin
                        snap[k] <= bank_in[k];
                     end
                     // Snapshot loads on this same edge, so the first word comes straight from the bank
                     dataOut   <= bank_in[startAddr];
                     remaining <= count;
                     outValid  <= 1'b1;
                     busy      <= 1'b1;
                     state     <= ST_STREAM;
                  end else begin
                     error <= 1'b1;
                  end
               end
            end
            ST_STREAM: begin
               if (hs) begin
                  if (remaining > AW'(1)) begin
                     remaining <= remaining - 1'b1;
                     dataOut   <= snap[addr_nxt];
                  end else begin
                     outValid <= 1'b0;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     state    <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
